dac_spi_tx: RTL and testbench

- SPI transmitter that serialises 12-bit samples into a 3-wire DAC interface (SYNC/SCLK/DIN, DAC121S101-style frame).
- This is the outbound counterpart of the ADC serial receiver path in the same design.
- Runs on the system clock and derives SCLK internally.
- Upstream logic supplies a sample with a one-cycle start; the block returns a done tick when the frame has been shifted out.

---
 rtl/dac_spi_tx.sv | 122 ++++++++++++
 tb/tb_dac_spi_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// Serialises 12-bit samples into a 16-bit SYNC/SCLK/DIN frame for a DAC121S101-style DAC.
// SCLK is derived from clk by a divider; all outputs are registered.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [1:0]  PD_MODE = 2'b00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] data_in,
  output logic        busy,
  output logic        tx_done_tick,
  output logic        SCLK,
  output logic        SYNC,
  output logic        DIN
);

  // state  | meaning
  // IDLE   | waiting for start, SYNC/SCLK high
  // SHIFT  | SYNC low, 32 SCLK half-periods, DIN changes on SCLK rise
  // FINISH | SYNC high hold of CLK_DIV clocks before the done tick
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [7:0]  div, div_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [15:0] shreg, shreg_n;
  logic [15:0] frame;
  logic        sclk_n, sync_n, din_n, busy_n, done_n;
  logic        div_tc;

  assign frame  = {2'b00, PD_MODE, data_in};
  assign div_tc = (div == DIV_TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      SCLK         <= 1'b1;
      SYNC         <= 1'b1;
      DIN          <= 1'b0;
      busy         <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      div          <= div_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      SCLK         <= sclk_n;
      SYNC         <= sync_n;
      DIN          <= din_n;
      busy         <= busy_n;
      tx_done_tick <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_n     = div;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    sclk_n    = SCLK;
    sync_n    = SYNC;
    din_n     = DIN;
    busy_n    = busy;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_n   = frame;
          sync_n    = 1'b0;
          din_n     = frame[15];
          sclk_n    = 1'b1;
          busy_n    = 1'b1;
          bit_cnt_n = '0;
          div_n     = '0;
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        if (div_tc) begin
          div_n  = '0;
          sclk_n = ~SCLK;
          // SCLK low now means this toggle is a rising edge
          if (!SCLK) begin
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              sync_n  = 1'b1;
              din_n   = 1'b0;
              state_n = FINISH;
            end else begin
              shreg_n = {shreg[14:0], 1'b0};
              din_n   = shreg[14];
            end
          end
        end else begin
          div_n = div + 8'd1;
        end
      end

      FINISH: begin
        if (div_tc) begin
          div_n   = '0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          div_n = div + 8'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: three instances (CLK_DIV=4/PD=00, CLK_DIV=4/PD=11, CLK_DIV=1/PD=00)
// with a DIN capture model that samples on SCLK falls.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic [11:0] data_v [3];
  logic [2:0]  busy_w, done_w, sclk_w, sync_w, din_w;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_tx #(.CLK_DIV(4), .PD_MODE(2'b00)) u_dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .data_in(data_v[0]),
    .busy(busy_w[0]), .tx_done_tick(done_w[0]), .SCLK(sclk_w[0]), .SYNC(sync_w[0]), .DIN(din_w[0]));

  dac_spi_tx #(.CLK_DIV(4), .PD_MODE(2'b11)) u_pd (
    .clk(clk), .reset(reset), .start(start_v[1]), .data_in(data_v[1]),
    .busy(busy_w[1]), .tx_done_tick(done_w[1]), .SCLK(sclk_w[1]), .SYNC(sync_w[1]), .DIN(din_w[1]));

  dac_spi_tx #(.CLK_DIV(1), .PD_MODE(2'b00)) u_fast (
    .clk(clk), .reset(reset), .start(start_v[2]), .data_in(data_v[2]),
    .busy(busy_w[2]), .tx_done_tick(done_w[2]), .SCLK(sclk_w[2]), .SYNC(sync_w[2]), .DIN(din_w[2]));

  int total = 0;
  int bad   = 0;

  // capture model state, one slot per instance
  int          falls [3], sync_low [3], sync_high [3], gap_min [3], dones [3];
  int          nframes [3], ndone [3], nbf [3];
  logic [15:0] cap [3];
  logic        prev_sclk [3], prev_sync [3], prev_busy [3];
  logic [15:0] frames [3][8];
  int          frame_falls [3][8], frame_sl [3][8], done_cyc [3][8], busy_fall [3][8];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        prev_sclk[i] = 1'b1;
        prev_sync[i] = 1'b1;
        prev_busy[i] = 1'b0;
        falls[i]     = 0;
        cap[i]       = '0;
        sync_low[i]  = 0;
        sync_high[i] = 0;
      end else begin
        if (prev_sclk[i] && !sclk_w[i]) begin
          falls[i] = falls[i] + 1;
          cap[i]   = {cap[i][14:0], din_w[i]};
        end
        if (!sync_w[i]) sync_low[i] = sync_low[i] + 1;
        if (sync_w[i]) sync_high[i] = sync_high[i] + 1;
        if (prev_sync[i] && !sync_w[i]) begin
          if (nframes[i] > 0 && sync_high[i] < gap_min[i]) gap_min[i] = sync_high[i];
          sync_high[i] = 0;
          cap[i]       = '0;
        end
        if (!prev_sync[i] && sync_w[i]) begin
          if (nframes[i] < 8) begin
            frames[i][nframes[i]]      = cap[i];
            frame_falls[i][nframes[i]] = falls[i];
            frame_sl[i][nframes[i]]    = sync_low[i];
          end
          nframes[i]  = nframes[i] + 1;
          falls[i]    = 0;
          sync_low[i] = 0;
        end
        if (done_w[i]) begin
          if (ndone[i] < 8) done_cyc[i][ndone[i]] = cyc;
          ndone[i] = ndone[i] + 1;
          dones[i] = dones[i] + 1;
        end
        if (prev_busy[i] && !busy_w[i]) begin
          if (nbf[i] < 8) busy_fall[i][nbf[i]] = cyc;
          nbf[i] = nbf[i] + 1;
        end
        prev_sclk[i] = sclk_w[i];
        prev_sync[i] = sync_w[i];
        prev_busy[i] = busy_w[i];
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      nframes[i] = 0;
      ndone[i]   = 0;
      nbf[i]     = 0;
      dones[i]   = 0;
      gap_min[i] = 1000;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset   = 1'b1;
    start_v = '0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_frame(input int i, input logic [11:0] d, output int e0);
    @(posedge clk); #1;
    start_v[i] = 1'b1;
    data_v[i]  = d;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    data_v[i]  = ~d;
    e0 = cyc;
  endtask

  task automatic wait_dones(input int i, input int target, input int budget, output bit ok);
    int k;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < budget) begin
      @(posedge clk); #1;
      if (dones[i] >= target) ok = 1'b1;
      k++;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = '0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    total++; if (sync_w !== 3'b111) begin bad++; $display("FAIL reset_sync got=%b want=111", sync_w); end
    total++; if (sclk_w !== 3'b111) begin bad++; $display("FAIL reset_sclk got=%b want=111", sclk_w); end
    total++; if (din_w !== 3'b000) begin bad++; $display("FAIL reset_din got=%b want=000", din_w); end
    total++; if (busy_w !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b want=000", busy_w); end
    total++; if (done_w !== 3'b000) begin bad++; $display("FAIL reset_done got=%b want=000", done_w); end
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++; if ({sync_w[0], sclk_w[0], din_w[0], busy_w[0], done_w[0]} !== 5'b11000) begin
      bad++; $display("FAIL reset_idle got=%b want=11000", {sync_w[0], sclk_w[0], din_w[0], busy_w[0], done_w[0]});
    end
    #1 reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    total++; if (dones[0] !== 0) begin bad++; $display("FAIL reset_no_done got=%0d want=0", dones[0]); end
  endtask

  task automatic test_single_frame();
    int e0;
    bit ok;
    apply_reset();
    start_frame(0, 12'hA5C, e0);
    total++; if ({busy_w[0], sync_w[0], sclk_w[0]} !== 3'b101) begin
      bad++; $display("FAIL accept_outputs got=%b want=101", {busy_w[0], sync_w[0], sclk_w[0]});
    end
    wait_dones(0, 1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=0 want=1"); end
    total++; if (frames[0][0] !== 16'h0A5C) begin bad++; $display("FAIL single_word got=%h want=0a5c", frames[0][0]); end
    total++; if (frame_falls[0][0] !== 16) begin bad++; $display("FAIL single_falls got=%0d want=16", frame_falls[0][0]); end
    total++; if (frame_sl[0][0] !== 128) begin bad++; $display("FAIL single_sync_low got=%0d want=128", frame_sl[0][0]); end
    total++; if (done_cyc[0][0] - e0 !== 132) begin bad++; $display("FAIL single_done_edge got=%0d want=132", done_cyc[0][0] - e0); end
    total++; if (busy_fall[0][0] !== done_cyc[0][0]) begin
      bad++; $display("FAIL single_busy_drop got=%0d want=%0d", busy_fall[0][0], done_cyc[0][0]);
    end
    repeat (20) @(posedge clk);
    #1;
    total++; if (dones[0] !== 1) begin bad++; $display("FAIL single_one_done got=%0d want=1", dones[0]); end
  endtask

  task automatic test_pd_header();
    int e0;
    bit ok;
    apply_reset();
    start_frame(1, 12'hFFF, e0);
    wait_dones(1, 1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL pd_timeout got=0 want=1"); end
    total++; if (frames[1][0] !== 16'h3FFF) begin bad++; $display("FAIL pd_word got=%h want=3fff", frames[1][0]); end
    total++; if (frame_falls[1][0] !== 16) begin bad++; $display("FAIL pd_falls got=%0d want=16", frame_falls[1][0]); end
  endtask

  task automatic test_start_while_busy();
    int e0;
    bit ok;
    apply_reset();
    start_frame(0, 12'h456, e0);
    repeat (39) @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    data_v[0]  = 12'h123;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_dones(0, 1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout got=0 want=1"); end
    total++; if (frames[0][0] !== 16'h0456) begin bad++; $display("FAIL busy_word got=%h want=0456", frames[0][0]); end
    repeat (200) @(posedge clk);
    #1;
    total++; if (dones[0] !== 1) begin bad++; $display("FAIL busy_dones got=%0d want=1", dones[0]); end
    total++; if (nframes[0] !== 1) begin bad++; $display("FAIL busy_frames got=%0d want=1", nframes[0]); end
  endtask

  task automatic test_back_to_back();
    int e0;
    bit ok1, ok2;
    apply_reset();
    @(posedge clk); #1;
    start_v[2] = 1'b1;
    data_v[2]  = 12'h000;
    @(posedge clk); #1;
    e0 = cyc;
    data_v[2] = 12'hFFF;
    wait_dones(2, 1, 100, ok1);
    start_v[2] = 1'b0;
    wait_dones(2, 2, 100, ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL b2b_timeout got=%0d%0d want=11", ok1, ok2); end
    total++; if (nframes[2] !== 2) begin bad++; $display("FAIL b2b_frames got=%0d want=2", nframes[2]); end
    total++; if (frames[2][0] !== 16'h0000) begin bad++; $display("FAIL b2b_word0 got=%h want=0000", frames[2][0]); end
    total++; if (frames[2][1] !== 16'h0FFF) begin bad++; $display("FAIL b2b_word1 got=%h want=0fff", frames[2][1]); end
    total++; if (done_cyc[2][0] - e0 !== 33) begin bad++; $display("FAIL b2b_first_done got=%0d want=33", done_cyc[2][0] - e0); end
    total++; if (done_cyc[2][1] - done_cyc[2][0] !== 34) begin
      bad++; $display("FAIL b2b_period got=%0d want=34", done_cyc[2][1] - done_cyc[2][0]);
    end
    total++; if (gap_min[2] < 2) begin bad++; $display("FAIL b2b_sync_gap got=%0d want>=2", gap_min[2]); end
    repeat (50) @(posedge clk);
    #1;
    total++; if (dones[2] !== 2) begin bad++; $display("FAIL b2b_dones got=%0d want=2", dones[2]); end
  endtask

  task automatic test_reset_mid_shift();
    int e0, k;
    bit ok;
    apply_reset();
    start_frame(0, 12'h7E5, e0);
    k = 0;
    while (falls[0] < 7 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    total++; if (falls[0] !== 7) begin bad++; $display("FAIL mid_falls got=%0d want=7", falls[0]); end
    reset = 1'b1;
    #1;
    total++; if ({sync_w[0], sclk_w[0], din_w[0], busy_w[0], done_w[0]} !== 5'b11000) begin
      bad++; $display("FAIL mid_reset_out got=%b want=11000", {sync_w[0], sclk_w[0], din_w[0], busy_w[0], done_w[0]});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    total++; if (dones[0] !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", dones[0]); end
    start_frame(0, 12'h081, e0);
    wait_dones(0, 1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout got=0 want=1"); end
    total++; if (frames[0][0] !== 16'h0081) begin bad++; $display("FAIL mid_word got=%h want=0081", frames[0][0]); end
    total++; if (frame_falls[0][0] !== 16) begin bad++; $display("FAIL mid_frame_falls got=%0d want=16", frame_falls[0][0]); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pd_header();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
